// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite movement controller:
//   - PS/2 scancode constants (extended prefix, break prefix, arrow make codes)
//   - scancode parser state encoding
//   - bit positions of the held-key flags inside the 4-bit key vector
//   - key_mask(): maps an arrow make code onto its one-hot flag bit
// -----------------------------------------------------------------------------
package sprite_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_t;

  // Key vector layout is {up, down, left, right}
  localparam int KEY_UP    = 3;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_RIGHT = 0;

  // One-hot flag for an arrow make code; zero for any other byte
  function automatic logic [3:0] key_mask(input logic [7:0] code);
    logic [3:0] mask;
    case (code)
      SC_UP:    mask = 4'b1000;
      SC_DOWN:  mask = 4'b0100;
      SC_LEFT:  mask = 4'b0010;
      SC_RIGHT: mask = 4'b0001;
      default:  mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ps2_scan_parser.sv
// -----------------------------------------------------------------------------
// ps2_scan_parser
// Tracks PS/2 prefix bytes (E0 / F0) and maintains the held state of the four
// arrow keys. Only cycles with i_key_en=1 advance the parser.
// Ports:
//   i_clk    : clock, all flops on rising edge
//   i_rst    : synchronous active-high reset (parser to IDLE, flags cleared)
//   i_key    : scancode byte
//   i_key_en : i_key valid strobe
//   o_keys   : registered held-key flags {up, down, left, right}
// -----------------------------------------------------------------------------
module ps2_scan_parser
  import sprite_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_key,
  input  logic       i_key_en,
  output logic [3:0] o_keys
);

  ps2_state_t r_state;
  ps2_state_t w_state_nxt;
  logic [3:0] r_keys;
  logic [3:0] w_keys_nxt;
  logic [3:0] w_mask;

  assign w_mask = key_mask(i_key);
  assign o_keys = r_keys;

  // Next-state and flag update: prefix tracking plus make/break decoding
  always_comb begin
    w_state_nxt = r_state;
    w_keys_nxt  = r_keys;
    if (i_key_en) begin
      case (r_state)
        IDLE: begin
          if (i_key == SC_EXT) begin
            w_state_nxt = EXT;
          end else if (i_key == SC_BRK) begin
            w_state_nxt = BRK;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        EXT: begin
          if (i_key == SC_BRK) begin
            w_state_nxt = EXT_BRK;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      // Prefix bytes have a zero mask, so they never disturb the flags
      if ((r_state == IDLE) || (r_state == EXT)) begin
        w_keys_nxt = r_keys | w_mask;
      end else begin
        w_keys_nxt = r_keys & ~w_mask;
      end
    end else begin
      w_state_nxt = r_state;
      w_keys_nxt  = r_keys;
    end
  end

  // Parser state and key-flag registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_keys  <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_keys  <= w_keys_nxt;
    end
  end

endmodule

// File: rtl/sprite_move_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_move_ctrl
// Moves a sprite box around the visible area under control of the PS/2 arrow
// keys. Positions update once every FRAME_DIV vertical-sync falls, one STEP
// per axis, limited to the visible area.
// Build option: define SPRITE_WRAP_EN to wrap at the edges instead of
// clamping (default build clamps and contains no wrap logic).
// Ports:
//   iVGA_CLK : clock, all flops on rising edge
//   iRST     : synchronous active-high reset
//   key_in   : PS/2 scancode byte
//   key_en   : key_in valid strobe
//   iVS      : vertical sync, active-low
//   oX, oY   : registered sprite position
//   oMove    : one-cycle pulse when oX or oY changed
//   oKeys    : held-key flags {up, down, left, right}
// -----------------------------------------------------------------------------
module sprite_move_ctrl
  import sprite_pkg::*;
#(
  parameter int X_INIT    = 320,
  parameter int Y_INIT    = 240,
  parameter int STEP      = 10,
  parameter int BOX_W     = 64,
  parameter int BOX_H     = 48,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int FRAME_DIV = 2
) (
  input  logic       iVGA_CLK,
  input  logic       iRST,
  input  logic [7:0] key_in,
  input  logic       key_en,
  input  logic       iVS,
  output logic [9:0] oX,
  output logic [9:0] oY,
  output logic       oMove,
  output logic [3:0] oKeys
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] X_MAX  = 11'(H_RES - 1 - BOX_W);
  localparam logic signed [10:0] Y_MAX  = 11'(V_RES - 1 - BOX_H);
  localparam logic signed [10:0] X_SPAN = 11'(H_RES - BOX_W);
  localparam logic signed [10:0] Y_SPAN = 11'(V_RES - BOX_H);

  logic             r_vs;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_move;

  logic             w_tick;
  logic             w_opp;
  logic [3:0]       w_keys;
  logic signed [10:0] w_x_cur;
  logic signed [10:0] w_y_cur;
  logic signed [10:0] w_x_nxt;
  logic signed [10:0] w_y_nxt;

  // One axis update: opposite flags cancel, then the result is kept in range
  function automatic logic signed [10:0] axis_next(
    input logic signed [10:0] pos,
    input logic               dec,
    input logic               inc,
    input logic signed [10:0] max_pos,
    input logic signed [10:0] span
  );
    logic signed [10:0] sum;
    if (inc && !dec) begin
      sum = pos + STEP_S;
    end else if (dec && !inc) begin
      sum = pos - STEP_S;
    end else begin
      sum = pos;
    end
`ifdef SPRITE_WRAP_EN
    if (sum < 11'sd0) begin
      sum = sum + span;
    end else if (sum > max_pos) begin
      sum = sum - span;
    end else begin
      sum = sum;
    end
`else
    if (sum < 11'sd0) begin
      sum = 11'sd0;
    end else if (sum > max_pos) begin
      sum = max_pos;
    end else begin
      sum = sum + (span - span);
    end
`endif
    return sum;
  endfunction

  ps2_scan_parser u_parser (
    .i_clk    (iVGA_CLK),
    .i_rst    (iRST),
    .i_key    (key_in),
    .i_key_en (key_en),
    .o_keys   (w_keys)
  );

  // Falling edge of the registered sync marks the start of a frame
  assign w_tick  = r_vs & ~iVS;
  assign w_opp   = w_tick && (r_frame_cnt == CNT_LAST);

  // w_keys is still the pre-edge flag set, so a key byte arriving on an
  // opportunity cycle only affects later moves
  assign w_x_cur = {1'b0, r_x};
  assign w_y_cur = {1'b0, r_y};
  assign w_x_nxt = axis_next(w_x_cur, w_keys[KEY_LEFT], w_keys[KEY_RIGHT], X_MAX, X_SPAN);
  assign w_y_nxt = axis_next(w_y_cur, w_keys[KEY_UP], w_keys[KEY_DOWN], Y_MAX, Y_SPAN);

  assign oX    = r_x;
  assign oY    = r_y;
  assign oMove = r_move;
  assign oKeys = w_keys;

  // Sync edge detector, frame divider and position registers
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_vs        <= 1'b1;
      r_frame_cnt <= '0;
      r_x         <= 10'(X_INIT);
      r_y         <= 10'(Y_INIT);
      r_move      <= 1'b0;
    end else begin
      r_vs <= iVS;
      if (w_tick) begin
        if (r_frame_cnt == CNT_LAST) begin
          r_frame_cnt <= '0;
        end else begin
          r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
      if (w_opp) begin
        r_x    <= w_x_nxt[9:0];
        r_y    <= w_y_nxt[9:0];
        r_move <= (w_x_nxt != w_x_cur) || (w_y_nxt != w_y_cur);
      end else begin
        r_x    <= r_x;
        r_y    <= r_y;
        r_move <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_move_ctrl
// Scoreboard bench: every driven frame fall pushes the expected position and
// move pulse from a behavioural model; a monitor pops and compares one cycle
// after the fall. Cycles with nothing expected must show oMove=0.
// -----------------------------------------------------------------------------
module tb_sprite_move_ctrl;

  localparam int X_INIT    = 320;
  localparam int Y_INIT    = 240;
  localparam int STEP      = 10;
  localparam int BOX_W     = 64;
  localparam int BOX_H     = 48;
  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int FRAME_DIV = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_in;
  logic       key_en;
  logic       vs;
  logic [9:0] ox;
  logic [9:0] oy;
  logic       omove;
  logic [3:0] okeys;

  always #5 clk = ~clk;

  sprite_move_ctrl #(
    .X_INIT(X_INIT), .Y_INIT(Y_INIT), .STEP(STEP), .BOX_W(BOX_W), .BOX_H(BOX_H),
    .H_RES(H_RES), .V_RES(V_RES), .FRAME_DIV(FRAME_DIV)
  ) dut (
    .iVGA_CLK (clk),
    .iRST     (rst),
    .key_in   (key_in),
    .key_en   (key_en),
    .iVS      (vs),
    .oX       (ox),
    .oY       (oy),
    .oMove    (omove),
    .oKeys    (okeys)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
    int mv;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;

  // reference model state
  int         m_x;
  int         m_y;
  int         m_cnt;
  int         m_ps;  // 0 idle, 1 after E0, 2 after F0, 3 after E0 F0
  logic [3:0] m_keys;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int move_axis(input int pos, input bit dec, input bit inc,
                                   input int res, input int box);
    int p;
    p = pos;
    if (inc && !dec) p = pos + STEP;
    if (dec && !inc) p = pos - STEP;
`ifdef SPRITE_WRAP_EN
    if (p < 0) p = p + (res - box);
    else if (p > res - 1 - box) p = p - (res - box);
`else
    if (p < 0) p = 0;
    else if (p > res - 1 - box) p = res - 1 - box;
`endif
    return p;
  endfunction

  task automatic model_tick();
    exp_t e;
    int nx;
    int ny;
    if (m_cnt == FRAME_DIV - 1) begin
      m_cnt = 0;
      nx = move_axis(m_x, m_keys[1], m_keys[0], H_RES, BOX_W);
      ny = move_axis(m_y, m_keys[3], m_keys[2], V_RES, BOX_H);
      e.mv = ((nx != m_x) || (ny != m_y)) ? 1 : 0;
      m_x = nx;
      m_y = ny;
    end else begin
      m_cnt++;
      e.mv = 0;
    end
    e.x = m_x;
    e.y = m_y;
    sb_q.push_back(e);
  endtask

  task automatic model_key(input logic [7:0] b);
    logic [3:0] mask;
    case (b)
      8'h75:   mask = 4'b1000;
      8'h72:   mask = 4'b0100;
      8'h6B:   mask = 4'b0010;
      8'h74:   mask = 4'b0001;
      default: mask = 4'b0000;
    endcase
    if (m_ps <= 1) m_keys = m_keys | mask;
    else           m_keys = m_keys & ~mask;
    if (m_ps == 0 && b == 8'hE0)      m_ps = 1;
    else if (m_ps == 0 && b == 8'hF0) m_ps = 2;
    else if (m_ps == 1 && b == 8'hF0) m_ps = 3;
    else                              m_ps = 0;
  endtask

  // One stimulus cycle: optional key byte and/or sync fall, then idle cycle
  task automatic drive(input bit ken, input logic [7:0] b, input bit fall);
    @(negedge clk);
    key_en = ken;
    key_in = b;
    if (fall) begin
      vs = 1'b0;
      model_tick();  // movement sees flags from before this byte
    end
    if (ken) model_key(b);
    @(negedge clk);
    key_en = 1'b0;
    key_in = 8'h00;
    vs     = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b, 1'b0);
    check_val("keys", okeys, m_keys);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_x = X_INIT; m_y = Y_INIT; m_cnt = 0; m_ps = 0; m_keys = 4'b0000;
    sb_q.delete();
    check_val("rst_x", ox, X_INIT);
    check_val("rst_y", oy, Y_INIT);
    check_val("rst_move", omove, 0);
    check_val("rst_keys", okeys, 0);
    mon_en = 1'b1;
  endtask

  // Monitor: compare scoreboard entries one cycle after each sync fall
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_val("sb_x", ox, mon_e.x);
        check_val("sb_y", oy, mon_e.y);
        check_val("sb_move", omove, mon_e.mv);
      end else begin
        check_val("idle_move", omove, 0);
      end
    end
  end

  initial begin
    rst = 1'b1; key_in = 8'h00; key_en = 1'b0; vs = 1'b1;
    do_reset();

    // extended up, two falls -> one step up on the second
    send(8'hE0); send(8'h75);
    check_val("up_held", okeys, 8);
    frames(2);
    check_val("up_y", oy, 230);
    check_val("up_x", ox, 320);

    // extended break of up, then nothing moves
    send(8'hE0); send(8'hF0); send(8'h75);
    check_val("up_released", okeys, 0);
    frames(4);
    check_val("no_move_y", oy, 230);

    // up and down together cancel
    send(8'h75); send(8'h72);
    check_val("updown_held", okeys, 12);
    frames(6);
    check_val("cancel_y", oy, 230);
    send(8'hF0); send(8'h75); send(8'hF0); send(8'h72);

    // key byte on the opportunity cycle: old flags move, parser takes E0
    send(8'h74);
    frames(1);
    drive(1'b1, 8'hE0, 1'b1);
    check_val("coincide_x", ox, 330);
    send(8'h74);
    check_val("right_still", okeys, 1);
    send(8'hF0); send(8'h74);

    // hold left for 70 opportunities
    send(8'h6B);
    frames(140);
`ifndef SPRITE_WRAP_EN
    check_val("left_clamp", ox, 0);
`endif
    send(8'hF0); send(8'h6B);

    // hold right to the right bound
    send(8'h74);
    frames(120);
`ifndef SPRITE_WRAP_EN
    check_val("right_clamp", ox, 575);
`endif
    send(8'hF0); send(8'h74);

    // hold down to the bottom bound
    send(8'h72);
    frames(50);
`ifndef SPRITE_WRAP_EN
    check_val("down_clamp", oy, 431);
`endif
    send(8'hF0); send(8'h72);

    // partial scancode discarded by reset
    send(8'hE0);
    do_reset();
    send(8'h74);
    check_val("post_rst_keys", okeys, 1);
    check_val("post_rst_x", ox, 320);
    frames(2);
    check_val("post_rst_move_x", ox, 330);

    repeat (3) @(negedge clk);
    check_val("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
